// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 memory responder.
// Holds the FSM state and operation encodings.
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_t;

  localparam logic [15:0] MMIO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_sram.sv
// Single-port synchronous RAM, DEPTH x 16.
// Write and registered read share one address.
module slc3_sram #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 CPU bus with wait states.
// Optional switch/hex I/O port enabled by SLC3_MMIO_EN.
module slc3_mem_responder
  import slc3_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_RD,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [9:0]  SW,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        ERR,
  output logic [15:0] HEX_OUT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  mem_op_t     op_q, op_d;
  logic [15:0] mdr_q, mdr_d;

  logic          resp;
  logic          ram_hit;
  logic          mmio_hit;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_rdata;
  logic [15:0]   rd_val;

  assign resp = (state_q == RESP);

`ifdef SLC3_MMIO_EN
  logic [15:0] hex_q, hex_d;
  assign mmio_hit = (addr_q == MMIO_ADDR);
  assign HEX_OUT  = hex_q;
`else
  logic unused_sw;
  assign unused_sw = ^SW;
  assign mmio_hit  = 1'b0;
  assign HEX_OUT   = 16'h0000;
`endif

  // The I/O port wins if it ever overlaps RAM.
  assign ram_hit = ((addr_q >> AW) == 16'd0) && !mmio_hit;

  // In IDLE the RAM reads straight from MAR so data is ready by RESP.
  assign ram_addr = (state_q == IDLE) ? MAR[AW-1:0] : addr_q[AW-1:0];
  assign ram_we   = resp && (op_q == OP_WR) && ram_hit && !Reset;

  slc3_sram #(
    .DEPTH(DEPTH)
  ) u_sram (
    .Clk  (Clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdat_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    rd_val = 16'h0000;
    if (ram_hit) begin
      rd_val = ram_rdata;
    end else if (mmio_hit) begin
      rd_val = {6'b0, SW};
    end
  end

  assign R      = resp;
  assign ERR    = resp && !ram_hit && !mmio_hit;
  assign MDR_In = (resp && op_q == OP_RD) ? rd_val : mdr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    op_d    = op_q;
    mdr_d   = MDR_In;
`ifdef SLC3_MMIO_EN
    hex_d   = hex_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (MEM_RD || MEM_WE) begin
          addr_d  = MAR;
          wdat_d  = MDR;
          op_d    = MEM_WE ? OP_WR : OP_RD;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
`ifdef SLC3_MMIO_EN
        if (op_q == OP_WR && mmio_hit) hex_d = wdat_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdat_q  <= 16'h0000;
      op_q    <= OP_RD;
      mdr_q   <= 16'h0000;
`ifdef SLC3_MMIO_EN
      hex_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      op_q    <= op_d;
      mdr_q   <= mdr_d;
`ifdef SLC3_MMIO_EN
      hex_q   <= hex_d;
`endif
    end
  end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder at WAIT_CYCLES 0, 2 and 5.
// Expected I/O-port results follow SLC3_MMIO_EN.
module tb_slc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MEM_RD, MEM_WE;
  logic [15:0] MAR, MDR;
  logic [9:0]  SW;
  logic [15:0] q0, q2, q5, h0, h2, h5;
  logic        r0, r2, r5, e0, e2, e5;

  int pass_n = 0;
  int tot_n  = 0;

  always #5 Clk = ~Clk;

  slc3_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .Clk(Clk), .Reset(Reset), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
    .MAR(MAR), .MDR(MDR), .SW(SW),
    .MDR_In(q0), .R(r0), .ERR(e0), .HEX_OUT(h0)
  );

  slc3_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u2 (
    .Clk(Clk), .Reset(Reset), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
    .MAR(MAR), .MDR(MDR), .SW(SW),
    .MDR_In(q2), .R(r2), .ERR(e2), .HEX_OUT(h2)
  );

  slc3_mem_responder #(.DEPTH(256), .WAIT_CYCLES(5)) u5 (
    .Clk(Clk), .Reset(Reset), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
    .MAR(MAR), .MDR(MDR), .SW(SW),
    .MDR_In(q5), .R(r5), .ERR(e5), .HEX_OUT(h5)
  );

  typedef struct {
    logic        rd;
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] q;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tot_n++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      pass_n++;
  endtask

  task automatic txn(input logic rd, input logic we,
                     input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] q, output logic e,
                     output int lat, output logic r_after);
    @(negedge Clk);
    MEM_RD = rd; MEM_WE = we; MAR = a; MDR = d;
    @(posedge Clk); #1;
    lat = 1;
    while (!r2 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    q = q2;
    e = e2;
    MEM_RD = 1'b0; MEM_WE = 1'b0;
    @(posedge Clk); #1;
    r_after = r2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] q, last, exp_hex;
    logic        e, ra;
    int          lat, n;
    int          f0, f2, f5, w0, w2, w5;
    logic [15:0] d0, d2, d5;

    Reset = 1'b1; MEM_RD = 1'b0; MEM_WE = 1'b0;
    MAR = 16'h0; MDR = 16'h0; SW = 10'h2A5;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_R", {15'b0, r2}, 16'h0);
    chk("rst_ERR", {15'b0, e2}, 16'h0);
    chk("rst_MDR_In", q2, 16'h0);
    chk("rst_HEX", h2, 16'h0);
    @(negedge Clk);
    Reset = 1'b0;

    txn(1'b0, 1'b1, 16'h0010, 16'h1111, q, e, lat, ra);
    @(negedge Clk);
    MEM_WE = 1'b1; MAR = 16'h0010; MDR = 16'h2222;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1; MEM_WE = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rstw_R", {15'b0, r2}, 16'h0);
    chk("rstw_MDR_In", q2, 16'h0);
    chk("rstw_HEX", h2, 16'h0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    txn(1'b1, 1'b0, 16'h0010, 16'h0, q, e, lat, ra);
    chk("rstw_old_data", q, 16'h1111);
    last = 16'h1111;

    vecs.push_back('{1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'h0005, 16'h0, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0001, 16'h0A01, 16'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0002, 16'h0A02, 16'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0003, 16'h0A03, 16'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h5A5A, 16'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'h0100, 16'h0, 16'h0000, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 16'h0007, 16'h1234, 16'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'h0007, 16'h0, 16'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h00FF, 16'h7777, 16'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'h00FF, 16'h0, 16'h7777, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0100, 16'h9999, 16'h0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h0, 16'h5A5A, 1'b0});
`ifdef SLC3_MMIO_EN
    vecs.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h02A5, 1'b0});
    vecs.push_back('{0, 1'b1, 16'hFFFF, 16'h00C3, 16'h0, 1'b0});
    exp_hex = 16'h00C3;
`else
    vecs.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h00C3, 16'h0, 1'b1});
    exp_hex = 16'h0000;
`endif

    foreach (vecs[i]) begin
      txn(vecs[i].rd, vecs[i].we, vecs[i].a, vecs[i].d, q, e, lat, ra);
      if (vecs[i].rd && !vecs[i].we) last = vecs[i].q;
      chk($sformatf("v%0d_MDR_In", i), q, last);
      chk($sformatf("v%0d_ERR", i), {15'b0, e}, {15'b0, vecs[i].e});
      chk($sformatf("v%0d_lat", i), 16'(lat), 16'd3);
      chk($sformatf("v%0d_Rwidth", i), {15'b0, ra}, 16'h0);
    end
    chk("hex_out", h2, exp_hex);

    @(negedge Clk);
    MEM_RD = 1'b1; MEM_WE = 1'b0; MAR = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge Clk); #1;
        n++;
      end while (!r2 && n < 40);
      chk($sformatf("held%0d_data", k), q2, 16'h0A01 + 16'(k));
      chk($sformatf("held%0d_gap", k), 16'(n), (k == 0) ? 16'd3 : 16'd4);
      MAR = 16'(k + 2);
      if (k == 2) MEM_RD = 1'b0;
    end
    @(posedge Clk); #1;
    chk("held_end_R", {15'b0, r2}, 16'h0);

    repeat (10) @(posedge Clk);
    @(negedge Clk);
    MEM_WE = 1'b1; MAR = 16'h0000; MDR = 16'h3C3C;
    repeat (20) @(posedge Clk);
    @(negedge Clk);
    MEM_WE = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    MEM_RD = 1'b1; MAR = 16'h0000;
    @(posedge Clk); #1;
    MEM_RD = 1'b0;
    f0 = 0; f2 = 0; f5 = 0; w0 = 0; w2 = 0; w5 = 0;
    d0 = 16'h0; d2 = 16'h0; d5 = 16'h0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin
        @(posedge Clk); #1;
      end
      if (r0) begin if (f0 == 0) f0 = c; w0++; d0 = q0; end
      if (r2) begin if (f2 == 0) f2 = c; w2++; d2 = q2; end
      if (r5) begin if (f5 == 0) f5 = c; w5++; d5 = q5; end
    end
    chk("lat_w0", 16'(f0), 16'd1);
    chk("lat_w2", 16'(f2), 16'd3);
    chk("lat_w5", 16'(f5), 16'd6);
    chk("width_w0", 16'(w0), 16'd1);
    chk("width_w2", 16'(w2), 16'd1);
    chk("width_w5", 16'(w5), 16'd1);
    chk("data_w0", d0, 16'h3C3C);
    chk("data_w2", d2, 16'h3C3C);
    chk("data_w5", d5, 16'h3C3C);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
